pct_access_ctrl: RTL and testbench
==================================

// Module: pct_access_ctrl
// PURPOSE
//  Sequences all accesses to the Process Context Table (PCT) single-port SRAM on behalf of the top FSM.
//  Accepts LOAD, SAVE, SWAP (save old PID, then load new PID) and CLEAR requests, drives the SRAM port,
//  and returns one response per request with a fixed latency for each op.
//  Tracks which PIDs hold a valid context. A never-written PID loads as all-zero (initial ct/ht, br_cnt=0).
// PARAMETERS
//  PID_bit   10    PID width; table depth = 2**PID_bit
//  ENTRY_W   134   entry width: {br_cnt[4:0], br_done_flag, ct[63:0], ht[63:0]}
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        asynchronous, active-high reset
//  req_valid      in   1        request present
//  req_ready      out  1        controller idle; request accepted when req_valid & req_ready
//  req_op         in   2        0=LOAD 1=SAVE 2=SWAP 3=CLEAR
//  req_save_pid   in   PID_bit  PID written by SAVE/SWAP
//  req_load_pid   in   PID_bit  PID read by LOAD/SWAP
//  req_wdata      in   ENTRY_W  context written by SAVE/SWAP
//  rsp_valid      out  1        one-cycle completion pulse; no backpressure
//  rsp_hit        out  1        LOAD/SWAP: loaded PID held a valid context
//  rsp_rdata      out  ENTRY_W  loaded context (zero on miss, and zero for SAVE/CLEAR)
//  busy           out  1        state != IDLE
//  mem_en         out  1        SRAM enable
//  mem_we         out  1        SRAM write enable
//  mem_addr       out  PID_bit  SRAM address
//  mem_wdata      out  ENTRY_W  SRAM write data
//  mem_rdata      in   ENTRY_W  SRAM read data, valid 1 cycle after the mem_en read cycle
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rsp_hit=0, rsp_rdata=0, busy=0, mem_en=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, state=IDLE, valid map all 0.
//  FSM states: IDLE, WR, RD, RDW, RSP. req_ready=1 only in IDLE. Request fields are captured at accept.
//  The mem_* outputs are decoded from registered state and captured fields. They are 0 in every state
//   that does not access the SRAM.
//  Let T be the accept edge. Cycle T+k denotes the cycle that begins k edges after T.
//  SAVE:  IDLE->WR->RSP->IDLE.
//   WR: mem_en=1, mem_we=1, addr=save_pid, wdata=req_wdata; valid[save_pid] set at the end of WR.
//   rsp_valid in cycle T+2.
//  LOAD:  IDLE->RD->RDW->RSP->IDLE.
//   RD: mem_en=valid[load_pid], mem_we=0, addr=load_pid.
//   RDW: rsp_rdata<=hit ? mem_rdata : 0, and rsp_hit<=hit.
//   rsp_valid in cycle T+3 for both hit and miss; a miss produces no SRAM read.
//  SWAP:  IDLE->WR->RD->RDW->RSP->IDLE. rsp_valid in cycle T+4.
//   Read-hit is evaluated after the write.
//   If save_pid==load_pid: RD issues no SRAM access, rsp_rdata=req_wdata (forwarded), rsp_hit=1.
//  CLEAR: IDLE->RSP->IDLE. The valid map is cleared at the end of IDLE(T+0). rsp_valid in cycle T+1.
//   SRAM contents are untouched.
//  rsp_rdata and rsp_hit hold their value until the next response.
//  During SAVE/CLEAR, rsp_rdata=0 and rsp_hit=0 in the RSP cycle.
//  A request in the RSP cycle is not accepted (req_ready=0). Back-to-back throughput is
//   one op every latency+1 cycles.
//  A req_valid held while busy is ignored. It stays pending and is accepted when the FSM reaches IDLE.
//  Reset mid-operation: all outputs go to reset values immediately (asynchronous).
//   An in-flight write is abandoned.
//   The valid map clears, so every PID subsequently loads as a miss.
// STRUCTURE
//  Shared package pct_pkg:
//   - op encodings PCT_LOAD/SAVE/SWAP/CLEAR
//   - entry field offsets BRCNT_MSB=133, BRCNT_LSB=129, BRDONE=128, CT_MSB=127, CT_LSB=64, HT_MSB=63, HT_LSB=0
//   - FSM state localparams
//  Sub-module pct_valid_map: 2**PID_bit-bit register with set(idx), test(idx) (combinational),
//   and clear_all (1 cycle); async reset to 0.
// TESTING
//  1. LOAD pid 5 after reset -> rsp_valid at T+3, rsp_hit=0, rsp_rdata=0, mem_en never asserted.
//  2. SAVE pid 5 data 0x...A5, then LOAD pid 5 -> write pulse mem_en=mem_we=1 addr=5 at T+1;
//     LOAD returns hit=1, rdata=0x...A5 at T+3.
//  3. SWAP save=5 load=9 (9 never written) -> write to 5 at T+1, no read, rsp at T+4 with hit=0, rdata=0;
//     SWAP save=9 load=5 -> hit=1, rdata=pid 5 data.
//  4. SWAP save=7 load=7 data X -> one write to 7, no read, rsp hit=1, rdata=X at T+4.
//  5. SAVE pid 3, CLEAR, LOAD pid 3 -> CLEAR rsp at T+1; LOAD misses (hit=0, rdata=0).
//  6. Assert reset during the RD cycle of a LOAD -> mem_en=0, rsp_valid=0, req_ready=1 immediately;
//     no response is issued.

Source files
------------

// File: rtl/pct_pkg.sv
// Shared definitions for the Process Context Table access controller:
// op encodings, entry field offsets and FSM states.
package pct_pkg;

  localparam int PID_BIT = 10;
  localparam int ENTRY_W = 134;

  localparam logic [1:0] PCT_LOAD  = 2'd0;
  localparam logic [1:0] PCT_SAVE  = 2'd1;
  localparam logic [1:0] PCT_SWAP  = 2'd2;
  localparam logic [1:0] PCT_CLEAR = 2'd3;

  localparam int BRCNT_MSB = 133;
  localparam int BRCNT_LSB = 129;
  localparam int BRDONE    = 128;
  localparam int CT_MSB    = 127;
  localparam int CT_LSB    = 64;
  localparam int HT_MSB    = 63;
  localparam int HT_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RDW  = 3'd3,
    ST_RSP  = 3'd4
  } pct_state_e;

endpackage

// File: rtl/pct_access_ctrl_if.sv
// Request/response and SRAM port bundle of the PCT access controller.
// master = requester plus SRAM side, slave = the controller.
interface pct_access_ctrl_if
  import pct_pkg::*;
#(
  parameter int PID_bit = PID_BIT,
  parameter int ENTRY_W = pct_pkg::ENTRY_W
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [PID_bit-1:0] req_save_pid;
  logic [PID_bit-1:0] req_load_pid;
  logic [ENTRY_W-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_hit;
  logic [ENTRY_W-1:0] rsp_rdata;
  logic               busy;
  logic               mem_en;
  logic               mem_we;
  logic [PID_bit-1:0] mem_addr;
  logic [ENTRY_W-1:0] mem_wdata;
  logic [ENTRY_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_op, req_save_pid, req_load_pid, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_hit, rsp_rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_save_pid, req_load_pid, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_hit, rsp_rdata, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pct_valid_map.sv
// One valid bit per PID: single-bit set, combinational test, whole-map clear.
// Clear wins over set when both arrive in the same cycle.
module pct_valid_map
  import pct_pkg::*;
#(
  parameter int PID_bit = PID_BIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_set,
  input  logic [PID_bit-1:0] i_set_idx,
  input  logic               i_clear_all,
  input  logic [PID_bit-1:0] i_test_idx,
  output logic               o_test
);

  logic [(2**PID_bit)-1:0] r_map;

  // valid bit storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_map <= '0;
    end else if (i_clear_all) begin
      r_map <= '0;
    end else if (i_set) begin
      r_map[i_set_idx] <= 1'b1;
    end
  end

  assign o_test = r_map[i_test_idx];

endmodule

// File: rtl/pct_access_ctrl.sv
// Sequences LOAD/SAVE/SWAP/CLEAR accesses to the single-port PCT SRAM and
// returns one fixed-latency response per request.
module pct_access_ctrl
  import pct_pkg::*;
#(
  parameter int PID_bit = PID_BIT,
  parameter int ENTRY_W = pct_pkg::ENTRY_W
) (
  input  logic              clk,
  input  logic              reset,
  pct_access_ctrl_if.slave  bus
);

  pct_state_e         r_state;
  pct_state_e         w_state_nxt;
  logic [1:0]         r_op;
  logic [PID_bit-1:0] r_save_pid;
  logic [PID_bit-1:0] r_load_pid;
  logic [ENTRY_W-1:0] r_wdata;
  logic               r_hit;
  logic               r_rsp_hit;
  logic [ENTRY_W-1:0] r_rsp_rdata;

  logic               w_accept;
  logic               w_fwd;
  logic               w_test;
  logic               w_rsp_clear;
  logic               w_mem_en;
  logic               w_mem_we;
  logic [PID_bit-1:0] w_mem_addr;
  logic [ENTRY_W-1:0] w_mem_wdata;

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);
  // SWAP to the same PID never reads the SRAM: the just-written data is forwarded
  assign w_fwd    = (r_op == PCT_SWAP) && (r_save_pid == r_load_pid);
  assign w_rsp_clear = (w_accept && (bus.req_op == PCT_CLEAR)) ||
                       ((r_state == ST_WR) && (r_op == PCT_SAVE));

  pct_valid_map #(.PID_bit(PID_bit)) u_valid_map (
    .clk         (clk),
    .reset       (reset),
    .i_set       (r_state == ST_WR),
    .i_set_idx   (r_save_pid),
    .i_clear_all (w_accept && (bus.req_op == PCT_CLEAR)),
    .i_test_idx  (r_load_pid),
    .o_test      (w_test)
  );

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (bus.req_op)
            PCT_LOAD: w_state_nxt = ST_RD;
            PCT_SAVE: w_state_nxt = ST_WR;
            PCT_SWAP: w_state_nxt = ST_WR;
            default:  w_state_nxt = ST_RSP;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR:   w_state_nxt = (r_op == PCT_SWAP) ? ST_RD : ST_RSP;
      ST_RD:   w_state_nxt = ST_RDW;
      ST_RDW:  w_state_nxt = ST_RSP;
      ST_RSP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // SRAM port decode from registered state and captured fields
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      ST_WR: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_save_pid;
        w_mem_wdata = r_wdata;
      end
      ST_RD: begin
        w_mem_en   = w_test && !w_fwd;
        w_mem_addr = r_load_pid;
      end
      default: begin
        w_mem_en = 1'b0;
      end
    endcase
  end

  // state, captured request and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= PCT_LOAD;
      r_save_pid  <= '0;
      r_load_pid  <= '0;
      r_wdata     <= '0;
      r_hit       <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op       <= bus.req_op;
        r_save_pid <= bus.req_save_pid;
        r_load_pid <= bus.req_load_pid;
        r_wdata    <= bus.req_wdata;
      end
      if (r_state == ST_RD) begin
        r_hit <= w_fwd || w_test;
      end
      if (r_state == ST_RDW) begin
        r_rsp_hit   <= r_hit;
        r_rsp_rdata <= w_fwd ? r_wdata : (r_hit ? bus.mem_rdata : '0);
      end else if (w_rsp_clear) begin
        r_rsp_hit   <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RSP);
  assign bus.rsp_hit   = r_rsp_hit;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_pct_access_ctrl.sv
// Self-checking bench for pct_access_ctrl: directed scenarios plus random ops
// against a table-level model of valid flags and stored contexts.
module tb_pct_access_ctrl;
  import pct_pkg::*;

  localparam int PW = 10;
  localparam int EW = 134;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pct_access_ctrl_if #(.PID_bit(PW), .ENTRY_W(EW)) bus ();

  pct_access_ctrl #(.PID_bit(PW), .ENTRY_W(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM model; non-read cycles return garbage so stale data cannot look right
  logic [EW-1:0] sram [0:(2**PW)-1];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      sram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= {$urandom, $urandom, $urandom, $urandom, $urandom};
    end else if (bus.mem_en) begin
      bus.mem_rdata <= sram[bus.mem_addr];
    end else begin
      bus.mem_rdata <= {$urandom, $urandom, $urandom, $urandom, $urandom};
    end
  end

  bit            m_valid [0:(2**PW)-1];
  logic [EW-1:0] m_ctx   [0:(2**PW)-1];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] rnd_entry();
    logic [159:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return v[EW-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2**PW; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [PW-1:0] sp,
                       input logic [PW-1:0] lp, input logic [EW-1:0] wd);
    int lat, rd_cyc, got_k, writes, reads, bad, exp_r;
    bit exp_hit, rdy_seen;
    logic [EW-1:0] exp_data, got_data;
    logic got_hit;
    lat = (op == PCT_LOAD) ? 3 : (op == PCT_SAVE) ? 2 : (op == PCT_SWAP) ? 4 : 1;
    rd_cyc = (op == PCT_SWAP) ? 2 : 1;
    exp_hit = 1'b0; exp_data = '0; exp_r = 0;
    if (op == PCT_SAVE || op == PCT_SWAP) begin
      m_valid[sp] = 1'b1;
      m_ctx[sp]   = wd;
    end
    if (op == PCT_CLEAR) model_clear();
    if (op == PCT_LOAD || op == PCT_SWAP) begin
      exp_hit  = m_valid[lp];
      exp_data = exp_hit ? m_ctx[lp] : '0;
      exp_r    = (exp_hit && !(op == PCT_SWAP && sp == lp)) ? 1 : 0;
    end
    rdy_seen = 1'b0;
    for (int i = 0; i < 20 && !rdy_seen; i++) begin
      @(negedge clk);
      rdy_seen = bus.req_ready;
    end
    check({tag, "_ready"}, rdy_seen, 1'b1);
    bus.req_op = op; bus.req_save_pid = sp; bus.req_load_pid = lp; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got_k = 0; writes = 0; reads = 0; bad = 0; got_hit = 1'b0; got_data = '0;
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_we) begin
        writes++;
        if (k != 1 || bus.mem_addr != sp || bus.mem_wdata != wd) bad++;
      end else if (bus.mem_en) begin
        reads++;
        if (k != rd_cyc || bus.mem_addr != lp) bad++;
      end
      if (k <= lat && (bus.req_ready || !bus.busy)) bad++;
      if (bus.rsp_valid) begin
        if (got_k != 0) bad++;
        got_k = k; got_hit = bus.rsp_hit; got_data = bus.rsp_rdata;
      end
    end
    check({tag, "_latency"}, got_k, lat);
    check({tag, "_hit"}, got_hit, exp_hit);
    check({tag, "_rdata"}, got_data, exp_data);
    check({tag, "_mem"}, {writes[7:0], reads[7:0], bad[7:0]},
          {((op == PCT_SAVE || op == PCT_SWAP) ? 8'd1 : 8'd0), exp_r[7:0], 8'd0});
  endtask

  initial begin
    logic [EW-1:0] d5, d7, d3, d20, d1023;
    int k_rsp [$];
    int bad;
    logic [1:0] op;
    int r;
    bit rst_rsp;
    model_clear();
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_save_pid = '0;
    bus.req_load_pid = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_outs", {bus.rsp_valid, bus.rsp_hit, bus.busy, bus.mem_en, bus.mem_we}, 5'b0);
    check("rst_bus", {bus.rsp_rdata, bus.mem_addr, bus.mem_wdata}, '0);
    reset = 1'b0;

    d5 = 134'h2_0123456789ABCDEF_FEDCBA98765432A5;
    do_op("t1_load_miss", PCT_LOAD, 10'd0, 10'd5, '0);
    do_op("t2_save5", PCT_SAVE, 10'd5, 10'd0, d5);
    do_op("t2_load5", PCT_LOAD, 10'd0, 10'd5, rnd_entry());
    do_op("t3_swap5_9", PCT_SWAP, 10'd5, 10'd9, d5);
    do_op("t3_swap9_5", PCT_SWAP, 10'd9, 10'd5, rnd_entry());
    d7 = rnd_entry();
    do_op("t4_swap7_7", PCT_SWAP, 10'd7, 10'd7, d7);
    d3 = rnd_entry();
    do_op("t5_save3", PCT_SAVE, 10'd3, 10'd0, d3);
    do_op("t5_clear", PCT_CLEAR, 10'd0, 10'd0, '0);
    do_op("t5_load3", PCT_LOAD, 10'd0, 10'd3, '0);
    d1023 = rnd_entry();
    do_op("edge_save1023", PCT_SAVE, 10'd1023, 10'd0, d1023);
    do_op("edge_load1023", PCT_LOAD, 10'd0, 10'd1023, '0);
    do_op("edge_load0", PCT_LOAD, 10'd1023, 10'd0, '0);

    // back-to-back: LOAD held pending while SAVE is busy
    d20 = rnd_entry();
    m_valid[20] = 1'b1; m_ctx[20] = d20;
    @(negedge clk);
    bus.req_op = PCT_SAVE; bus.req_save_pid = 10'd20; bus.req_wdata = d20;
    bus.req_load_pid = 10'd0; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_op = PCT_LOAD; bus.req_load_pid = 10'd20; bus.req_save_pid = 10'd1;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) k_rsp.push_back(k);
      if (k == 6 && (bus.rsp_hit !== 1'b1 || bus.rsp_rdata !== d20)) bad++;
      if (bus.req_ready && bus.req_valid) begin
        if (k != 3) bad++;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
      end
    end
    check("b2b_rsp_count", k_rsp.size(), 2);
    if (k_rsp.size() == 2) begin
      check("b2b_rsp_cycles", {k_rsp[0][7:0], k_rsp[1][7:0]}, {8'd2, 8'd6});
    end
    check("b2b_data", bad, 0);
    bus.req_valid = 1'b0;

    // reset in the RD cycle of a hitting LOAD
    @(negedge clk);
    bus.req_op = PCT_LOAD; bus.req_load_pid = 10'd20; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("t6_rd_before_reset", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 10'd20});
    reset = 1'b1;
    #1;
    check("t6_reset_now", {bus.mem_en, bus.rsp_valid, bus.req_ready, bus.busy}, 4'b0010);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    rst_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) rst_rsp = 1'b1;
    end
    check("t6_no_rsp", rst_rsp, 1'b0);
    do_op("t6_load20_after", PCT_LOAD, 10'd0, 10'd20, '0);

    // random ops over a small PID range so hits and aliasing are frequent
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? PCT_CLEAR : (r <= 3) ? PCT_LOAD : (r <= 6) ? PCT_SAVE : PCT_SWAP;
      do_op($sformatf("rnd%0d", i), op, 10'($urandom_range(0, 7)),
            10'($urandom_range(0, 7)), rnd_entry());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
